// File: rtl/udp_ip_rx.sv
// IPv4/UDP receive filter: checks the IPv4 header and the UDP destination, then streams
// the UDP payload with byte-accurate keep and truncation reporting.
module udp_ip_rx #(
  parameter int DATA_WIDTH = 32,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] mac_data,
  input  logic                  mac_valid,
  input  logic                  mac_last,
  input  logic [31:0]           local_ip,
  input  logic [15:0]           local_port,
  output logic [DATA_WIDTH-1:0] app_data,
  output logic [3:0]            app_keep,
  output logic                  app_valid,
  output logic                  app_last,
  output logic                  app_err,
  output logic [15:0]           app_len,
  output logic [31:0]           rx_src_ip,
  output logic [15:0]           rx_src_port,
  output logic                  pkt_ok,
  output logic                  pkt_drop,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic [2:0]            fsm_state
);

  // Input is a qualified stream with no backpressure: a word is consumed on every cycle
  // where mac_valid=1; outputs are a 1-cycle registered stream qualified by app_valid.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IP_HDR  = 3'd1,
    UDP_HDR = 3'd2,
    PAYLOAD = 3'd3,
    DROP    = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [2:0]  hdr_idx;
  logic [31:0] acc;
  logic [7:0]  ver_ihl;
  logic [15:0] total_len;
  logic        frag_bad;
  logic [7:0]  proto;
  logic [31:0] src_ip_q;
  logic [15:0] src_port_q;
  logic [15:0] rem;

  logic [15:0] w_hi, w_lo;
  logic [31:0] acc_base, acc_next;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic        ip_bad, udp_bad;
  logic [3:0]  keep_last;

  // Control strobes decided in the next-state process
  logic        reject, accept, ok_now, emit, last_now, err_now;
  logic [3:0]  keep_now;

  assign fsm_state = state;
  assign w_hi      = mac_data[31:16];
  assign w_lo      = mac_data[15:0];

  // W0 starts a fresh sum so a stale accumulator never leaks across frames
  assign acc_base  = (state == IDLE) ? 32'd0 : acc;
  assign acc_next  = acc_base + {16'd0, w_hi} + {16'd0, w_lo};
  assign fold1     = {1'b0, acc_next[15:0]} + {1'b0, acc_next[31:16]};
  assign fold2     = fold1[15:0] + {15'd0, fold1[16]};

  assign ip_bad    = (ver_ihl != 8'h45) | frag_bad | (proto != 8'd17) |
                     (fold2 != 16'hFFFF) | (mac_data != local_ip);
  // udp_len must fit inside the IP payload; 17-bit compare avoids total_len-20 underflow
  assign udp_bad   = (w_hi < 16'd8) | (({1'b0, w_hi} + 17'd20) > {1'b0, total_len});
  assign keep_last = {rem >= 16'd1, rem >= 16'd2, rem >= 16'd3, rem >= 16'd4};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    reject     = 1'b0;
    accept     = 1'b0;
    ok_now     = 1'b0;
    emit       = 1'b0;
    last_now   = 1'b0;
    err_now    = 1'b0;
    keep_now   = 4'b1111;
    if (mac_valid) begin
      case (state)
        IDLE: begin
          reject     = mac_last;
          state_next = mac_last ? IDLE : IP_HDR;
        end
        IP_HDR: begin
          if (hdr_idx == 3'd4) begin
            if (ip_bad || mac_last) begin
              reject     = 1'b1;
              state_next = mac_last ? IDLE : DROP;
            end else begin
              state_next = UDP_HDR;
            end
          end else if (mac_last) begin
            reject     = 1'b1;
            state_next = IDLE;
          end
        end
        UDP_HDR: begin
          if (hdr_idx == 3'd5) begin
            if ((w_lo != local_port) || mac_last) begin
              reject     = 1'b1;
              state_next = mac_last ? IDLE : DROP;
            end
          end else if (udp_bad || (mac_last && (w_hi != 16'd8))) begin
            reject     = 1'b1;
            state_next = mac_last ? IDLE : DROP;
          end else if (w_hi == 16'd8) begin
            accept     = 1'b1;
            ok_now     = 1'b1;
            state_next = mac_last ? IDLE : DROP;
          end else begin
            accept     = 1'b1;
            state_next = PAYLOAD;
          end
        end
        PAYLOAD: begin
          emit = 1'b1;
          if (rem <= 16'd4) begin
            last_now   = 1'b1;
            ok_now     = 1'b1;
            keep_now   = keep_last;
            state_next = mac_last ? IDLE : DROP;
          end else if (mac_last) begin
            last_now   = 1'b1;
            err_now    = 1'b1;
            reject     = 1'b1;
            state_next = IDLE;
          end
        end
        DROP: begin
          if (mac_last) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      app_data    <= '0;
      app_keep    <= '0;
      app_valid   <= 1'b0;
      app_last    <= 1'b0;
      app_err     <= 1'b0;
      app_len     <= '0;
      rx_src_ip   <= '0;
      rx_src_port <= '0;
      pkt_ok      <= 1'b0;
      pkt_drop    <= 1'b0;
      drop_cnt    <= '0;
      hdr_idx     <= '0;
      acc         <= '0;
      ver_ihl     <= '0;
      total_len   <= '0;
      frag_bad    <= 1'b0;
      proto       <= '0;
      src_ip_q    <= '0;
      src_port_q  <= '0;
      rem         <= '0;
    end else begin
      app_valid <= emit;
      app_last  <= last_now;
      app_err   <= err_now;
      pkt_ok    <= ok_now;
      pkt_drop  <= reject;
      if (emit) begin
        app_data <= mac_data;
        app_keep <= keep_now;
        rem      <= rem - 16'd4;
      end
      if (reject && !(&drop_cnt)) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      if (mac_valid) begin
        case (state)
          IDLE: begin
            acc       <= acc_next;
            ver_ihl   <= mac_data[31:24];
            total_len <= w_lo;
            hdr_idx   <= 3'd1;
          end
          IP_HDR: begin
            acc     <= acc_next;
            hdr_idx <= hdr_idx + 3'd1;
            // MF is bit 13 of the flags/offset half; any offset means a fragment
            if (hdr_idx == 3'd1) frag_bad <= |mac_data[13:0];
            if (hdr_idx == 3'd2) proto    <= mac_data[23:16];
            if (hdr_idx == 3'd3) src_ip_q <= mac_data;
          end
          UDP_HDR: begin
            hdr_idx <= hdr_idx + 3'd1;
            if (hdr_idx == 3'd5) src_port_q <= w_hi;
          end
          default: ;
        endcase
      end
      if (accept) begin
        app_len     <= w_hi - 16'd8;
        rem         <= w_hi - 16'd8;
        rx_src_ip   <= src_ip_q;
        rx_src_port <= src_port_q;
      end
    end
  end

endmodule
